// File: rtl/gpio_bank.sv
// gpio_bank: N-pin GPIO bank on the 8-bit 6502 bus with per-pin alt function muxing,
// 2-flop input sync and sticky edge-detect interrupts.
module gpio_bank #(
  parameter int N_PINS = 8,
  parameter int ADDR_W = 6
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_phi2,
  input  logic                i_en,
  input  logic                i_rw,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [7:0]          i_data,
  output logic [7:0]          o_data,
  input  logic [N_PINS-1:0]   i_pins,
  output logic [N_PINS-1:0]   o_pins,
  output logic [N_PINS-1:0]   o_pins_oe,
  input  logic [3*N_PINS-1:0] i_alt_out,
  input  logic [3*N_PINS-1:0] i_alt_oe,
  output logic [N_PINS-1:0]   o_pins_sync,
  output logic                o_irq
);
  localparam int NB = N_PINS / 8;
  logic                r_phi2_d, r_cap_en, r_cap_rw;
  logic [ADDR_W-1:0]   r_cap_addr;
  logic [7:0]          r_cap_data;
  logic [N_PINS-1:0]   r_out, r_dir, r_ien, r_irise, r_ifall, r_stat, r_s1, r_s2, r_s3;
  logic [2*N_PINS-1:0] r_fsel;
  logic                w_commit;
  logic [N_PINS-1:0]   w_rd [7];
  logic [N_PINS-1:0]   w_wm [7];
  logic [N_PINS-1:0]   w_wd, w_set;
  logic [2*N_PINS-1:0] w_fwm, w_fwd;
  // One commit per phi2 high period, on its falling edge, from the last captured bus state.
  assign w_commit = r_phi2_d & ~i_phi2 & r_cap_en & ~r_cap_rw;
  assign w_wd = {NB{r_cap_data}};
  assign w_fwd = {2*NB{r_cap_data}};
  assign w_rd[0] = r_out;
  assign w_rd[1] = r_dir;
  assign w_rd[2] = r_s2;
  assign w_rd[3] = r_ien;
  assign w_rd[4] = r_irise;
  assign w_rd[5] = r_ifall;
  assign w_rd[6] = r_stat;
  assign w_set = r_ien & ((r_irise & r_s2 & ~r_s3) | (r_ifall & ~r_s2 & r_s3));
  assign o_pins_sync = r_s2;
  assign o_irq = |r_stat;
  always_comb begin
    o_data = '0;
    w_fwm = '0;
    for (int r = 0; r < 7; r++) w_wm[r] = '0;
    for (int r = 0; r < 7; r++)
      for (int k = 0; k < NB; k++) begin
        if (i_addr == ADDR_W'(r*NB + k)) o_data = w_rd[r][8*k +: 8];
        if (w_commit && r_cap_addr == ADDR_W'(r*NB + k)) w_wm[r][8*k +: 8] = '1;
      end
    for (int j = 0; j < 2*NB; j++) begin
      if (i_addr == ADDR_W'(7*NB + j)) o_data = r_fsel[8*j +: 8];
      if (w_commit && r_cap_addr == ADDR_W'(7*NB + j)) w_fwm[8*j +: 8] = '1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phi2_d <= 1'b0;
      r_cap_en <= 1'b0;
      r_cap_rw <= 1'b0;
      r_cap_addr <= '0;
      r_cap_data <= '0;
      r_out <= '0;
      r_dir <= '0;
      r_ien <= '0;
      r_irise <= '0;
      r_ifall <= '0;
      r_stat <= '0;
      r_fsel <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
      o_pins <= '0;
      o_pins_oe <= '0;
    end else begin
      r_phi2_d <= i_phi2;
      if (i_phi2) begin
        r_cap_en <= i_en;
        r_cap_rw <= i_rw;
        r_cap_addr <= i_addr;
        r_cap_data <= i_data;
      end
      r_out <= (r_out & ~w_wm[0]) | (w_wd & w_wm[0]);
      r_dir <= (r_dir & ~w_wm[1]) | (w_wd & w_wm[1]);
      r_ien <= (r_ien & ~w_wm[3]) | (w_wd & w_wm[3]);
      r_irise <= (r_irise & ~w_wm[4]) | (w_wd & w_wm[4]);
      r_ifall <= (r_ifall & ~w_wm[5]) | (w_wd & w_wm[5]);
      r_stat <= (r_stat & ~(w_wm[6] & w_wd)) | w_set;
      r_fsel <= (r_fsel & ~w_fwm) | (w_fwd & w_fwm);
      r_s1 <= i_pins;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      for (int i = 0; i < N_PINS; i++) begin
        o_pins[i] <= r_fsel[2*i +: 2] == 2'd0 ? r_out[i] :
                     r_fsel[2*i +: 2] == 2'd1 ? i_alt_out[i] :
                     r_fsel[2*i +: 2] == 2'd2 ? i_alt_out[N_PINS + i] : i_alt_out[2*N_PINS + i];
        o_pins_oe[i] <= r_fsel[2*i +: 2] == 2'd0 ? r_dir[i] :
                        r_fsel[2*i +: 2] == 2'd1 ? i_alt_oe[i] :
                        r_fsel[2*i +: 2] == 2'd2 ? i_alt_oe[N_PINS + i] : i_alt_oe[2*N_PINS + i];
      end
    end
  end
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed + randomized checks of gpio_bank (16 pins) against a register-level model.
module tb_gpio_bank;
  localparam int NP = 16;
  localparam int NB = 2;
  logic i_clk = 0, i_reset = 0, i_phi2 = 0, i_en = 0, i_rw = 1;
  logic [5:0] i_addr = '0;
  logic [7:0] i_data = '0, o_data;
  logic [NP-1:0] i_pins = '0, o_pins, o_pins_oe, o_pins_sync;
  logic [3*NP-1:0] i_alt_out = '0, i_alt_oe = '0;
  logic o_irq;
  int n_vec = 0, n_err = 0;
  logic [15:0] m_reg [7];
  int m_fsel [16];
  gpio_bank #(.N_PINS(NP), .ADDR_W(6)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_phi2(i_phi2), .i_en(i_en), .i_rw(i_rw),
    .i_addr(i_addr), .i_data(i_data), .o_data(o_data), .i_pins(i_pins), .o_pins(o_pins),
    .o_pins_oe(o_pins_oe), .i_alt_out(i_alt_out), .i_alt_oe(i_alt_oe),
    .o_pins_sync(o_pins_sync), .o_irq(o_irq));
  always #5 i_clk = ~i_clk;
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic mreset();
    for (int r = 0; r < 7; r++) m_reg[r] = '0;
    for (int i = 0; i < 16; i++) m_fsel[i] = 0;
  endtask
  function automatic logic [7:0] mread(input int a);
    logic [15:0] v;
    logic [7:0] b;
    if (a < 7*NB) begin
      v = m_reg[a/NB];
      return v[8*(a%NB) +: 8];
    end
    if (a < 9*NB) begin
      for (int m = 0; m < 4; m++) b[2*m +: 2] = 2'(m_fsel[4*(a-7*NB) + m]);
      return b;
    end
    return 8'h00;
  endfunction
  task automatic mwrite(input int a, input logic [7:0] d);
    int r, k;
    if (a < 7*NB) begin
      r = a / NB;
      k = a % NB;
      if (r == 6) m_reg[6][8*k +: 8] = m_reg[6][8*k +: 8] & ~d;
      else if (r != 2) m_reg[r][8*k +: 8] = d;
    end else if (a < 9*NB)
      for (int m = 0; m < 4; m++) m_fsel[4*(a-7*NB) + m] = int'(d[2*m +: 2]);
  endtask
  function automatic logic [15:0] exp_pins(input bit oe);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) begin
      if (m_fsel[i] == 0) v[i] = oe ? m_reg[1][i] : m_reg[0][i];
      else v[i] = oe ? i_alt_oe[(m_fsel[i]-1)*16 + i] : i_alt_out[(m_fsel[i]-1)*16 + i];
    end
    return v;
  endfunction
  task automatic bus_write(input int a, input logic [7:0] d);
    i_en = 1; i_rw = 0; i_addr = 6'(a); i_data = d; i_phi2 = 1;
    tick();
    i_phi2 = 0;
    tick();
    i_en = 0; i_rw = 1;
    mwrite(a, d);
  endtask
  task automatic rd_chk(input int a);
    i_addr = 6'(a);
    #1;
    chk($sformatf("rd%0d", a), {24'h0, o_data}, {24'h0, mread(a)});
  endtask
  task automatic set_pins(input logic [15:0] v);
    logic [15:0] ri, fa;
    ri = v & ~m_reg[2];
    fa = ~v & m_reg[2];
    m_reg[6] = m_reg[6] | (m_reg[3] & ((m_reg[4] & ri) | (m_reg[5] & fa)));
    m_reg[2] = v;
    i_pins = v;
    repeat (3) tick();
  endtask
  task automatic chk_pins(input string tag);
    chk({tag, "_pins"}, {16'h0, o_pins}, {16'h0, exp_pins(0)});
    chk({tag, "_oe"}, {16'h0, o_pins_oe}, {16'h0, exp_pins(1)});
  endtask
  initial begin
    logic [7:0] d;
    mreset();
    i_reset = 1;
    repeat (2) tick();
    i_reset = 0;
    tick();
    for (int a = 0; a < 64; a++) rd_chk(a);
    chk("rst_pins", {16'h0, o_pins}, 0);
    chk("rst_oe", {16'h0, o_pins_oe}, 0);
    chk("rst_irq", {31'h0, o_irq}, 0);
    chk("rst_sync", {16'h0, o_pins_sync}, 0);
    bus_write(3, 8'hFF);
    bus_write(1, 8'hA5);
    tick();
    chk("dirout_pins", {16'h0, o_pins}, 32'hA500);
    chk("dirout_oe", {16'h0, o_pins_oe}, 32'hFF00);
    i_alt_out = 48'h1;
    i_alt_oe = 48'h1;
    bus_write(14, 8'h01);
    tick();
    chk("alt1_pins", {16'h0, o_pins}, 32'hA501);
    chk("alt1_oe", {16'h0, o_pins_oe}, 32'hFF01);
    bus_write(14, 8'h00);
    tick();
    chk("gpio_pins", {16'h0, o_pins}, 32'hA500);
    chk("gpio_oe", {16'h0, o_pins_oe}, 32'hFF00);
    bus_write(6, 8'h01);
    bus_write(8, 8'h01);
    i_pins = 16'h0001;
    repeat (2) tick();
    chk("irq_early", {31'h0, o_irq}, 0);
    tick();
    m_reg[2] = 16'h0001;
    m_reg[6] = 16'h0001;
    chk("irq_rise", {31'h0, o_irq}, 1);
    i_addr = 6'd12; #1;
    chk("stat_rise", {24'h0, o_data}, 32'h01);
    set_pins(16'h0000);
    i_addr = 6'd12; #1;
    chk("stat_fall", {24'h0, o_data}, 32'h01);
    bus_write(12, 8'h01);
    chk("irq_w1c", {31'h0, o_irq}, 0);
    rd_chk(12);
    i_en = 1; i_rw = 0; i_addr = 6'd0; i_phi2 = 1;
    d = 8'h00;
    for (int c = 0; c < 4; c++) begin
      d = 8'($urandom);
      i_data = d;
      tick();
      chk("hold_nocommit", {24'h0, o_data}, {24'h0, mread(0)});
    end
    i_phi2 = 0;
    i_data = ~d;
    tick();
    mwrite(0, d);
    chk("hold_commit", {24'h0, o_data}, {24'h0, d});
    tick();
    chk("hold_once", {24'h0, o_data}, {24'h0, d});
    i_en = 0; i_rw = 1;
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < 4; a++) bus_write(a, 8'($urandom));
      for (int a = 14; a < 18; a++) bus_write(a, 8'($urandom));
      i_alt_out = 48'({$urandom(), $urandom()});
      i_alt_oe = 48'({$urandom(), $urandom()});
      tick();
      chk_pins($sformatf("cfg%0d", it));
      for (int a = 0; a < 20; a++) rd_chk(a);
    end
    for (int a = 6; a < 12; a++) bus_write(a, 8'($urandom));
    for (int it = 0; it < 12; it++) begin
      set_pins(16'($urandom));
      rd_chk(4);
      rd_chk(5);
      rd_chk(12);
      rd_chk(13);
      chk("rnd_irq", {31'h0, o_irq}, {31'h0, |m_reg[6]});
      chk("rnd_sync", {16'h0, o_pins_sync}, {16'h0, m_reg[2]});
      if (it % 3 == 2) begin
        bus_write(12 + it % 2, 8'($urandom));
        rd_chk(12);
        rd_chk(13);
      end
    end
    set_pins(16'h0000);
    bus_write(6, 8'h04);
    bus_write(8, 8'h04);
    bus_write(12, 8'hFF);
    bus_write(13, 8'hFF);
    rd_chk(12);
    i_pins = 16'h0004;
    tick();
    i_en = 1; i_rw = 0; i_addr = 6'd12; i_data = 8'h04; i_phi2 = 1;
    tick();
    i_phi2 = 0;
    tick();
    i_en = 0; i_rw = 1;
    m_reg[2] = 16'h0004;
    m_reg[6] = m_reg[6] | 16'h0004;
    i_addr = 6'd12; #1;
    chk("coinc_bit2", {31'h0, o_data[2]}, 1);
    rd_chk(12);
    set_pins(16'h0000);
    i_en = 1; i_rw = 0; i_addr = 6'd1; i_data = 8'h77; i_phi2 = 1;
    tick();
    i_phi2 = 0;
    i_reset = 1;
    tick();
    i_reset = 0;
    i_en = 0; i_rw = 1;
    mreset();
    tick();
    for (int a = 0; a < 64; a++) rd_chk(a);
    chk("rst2_pins", {16'h0, o_pins}, 0);
    chk("rst2_oe", {16'h0, o_pins_oe}, 0);
    chk("rst2_irq", {31'h0, o_irq}, 0);
    chk("rst2_sync", {16'h0, o_pins_sync}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised GPIO bank for the 6502 SoC, successor to the fixed 8-pin GPIO with hard-wired UART0/SK6812 muxing. Provides N_PINS pins on the 8-bit CPU bus, each with a per-pin function select (GPIO or one of three alternate peripheral channels). It adds 2-flop input synchronisation and per-pin edge-detect interrupts with sticky write-1-to-clear status, aggregated onto one interrupt line for the CPU.

## Interface
- N_PINS, 8: pin count; multiple of 8, range 8..32; NB = N_PINS/8.
- ADDR_W, 6: bus address width; 9*NB <= 2^ADDR_W.
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_phi2  in  1  CPU phase-2 level, sampled on i_clk.
- i_en  in  1  chip select.
- i_rw  in  1  1 = read, 0 = write.
- i_addr  in  ADDR_W  register byte address.
- i_data  in  8  write data.
- o_data  out  8  read data, combinational from i_addr.
- i_pins  in  N_PINS  pad inputs, asynchronous.
- o_pins  out  N_PINS  pad output values, registered.
- o_pins_oe  out  N_PINS  pad output enables, registered; 1 = drive.
- i_alt_out  in  3*N_PINS  alt channel c (1..3) pin i output at bit (c-1)*N_PINS+i.
- i_alt_oe  in  3*N_PINS  alt channel output enables, same packing.
- o_pins_sync  out  N_PINS  synchronised pin levels, for peripherals (e.g. UART RX).
- o_irq  out  1  OR of all IRQ_STATUS bits, active-high.

## Operation
- Register r, byte k (pins 8k..8k+7) at address r*NB + k: r0 OUT, r1 DIR (1 = output), r2 IN (RO = o_pins_sync), r3 IRQ_EN, r4 IRQ_RISE, r5 IRQ_FALL, r6 IRQ_STATUS (W1C).
- FSEL: 2 bits per pin at addresses 7*NB + j, j = 0..2*NB-1; byte j holds pins 4j..4j+3, pin 4j+m in bits [2m+1:2m]. 0 = GPIO, 1..3 = alt channel.
- Unmapped and out-of-range addresses read 0; writes to them and to IN are ignored.
- Bus capture: each cycle with i_phi2 = 1, register cap_en, cap_rw, cap_addr, cap_data and phi2_d <= i_phi2.
- Write commit: on the cycle where phi2_d = 1 and i_phi2 = 0, and cap_en = 1 and cap_rw = 0. Exactly one commit per phi2 high period. Reads have no side effects.
- Pin i output, registered each cycle:
  - FSEL = 0: o_pins = OUT[i], o_pins_oe = DIR[i].
  - FSEL = f: o_pins = i_alt_out[(f-1)*N_PINS+i], o_pins_oe = i_alt_oe[...].
- Sync chain per pin: s1 <= i_pins, s2 <= s1, s3 <= s2. o_pins_sync = s2. rise = s2 & ~s3, fall = ~s2 & s3.
- Status set for pin i when IRQ_EN[i] & ((IRQ_RISE[i] & rise) | (IRQ_FALL[i] & fall)). Status is sticky until cleared.
- Writing 1 to a STATUS bit clears it. If a set and a W1C hit the same bit in the same cycle, set wins. Clearing IRQ_EN does not clear STATUS.
- Reset state: all registers, sync flops, phi2_d and capture flops = 0. o_pins = 0, o_pins_oe = 0, o_irq = 0, o_pins_sync = 0. Reset mid-write discards the pending commit.

## Timing
- Write commits at edge E. The register holds the new value after E; o_pins/o_pins_oe reflect it after E+1.
- i_alt_out/i_alt_oe to o_pins/o_pins_oe: 1 cycle.
- Pin change sampled at edge n: o_pins_sync/IN update after n+1, STATUS and o_irq after n+2.
- o_data is valid in the same cycle as i_addr, with no wait states.
- A pin pulse shorter than one i_clk period may be missed. A pulse held for 2 or more cycles produces exactly one rise event and one fall event.

## Test plan
- Reset, then read all addresses -> every register reads 0x00; o_pins, o_pins_oe, o_irq all 0.
- N_PINS=16: write DIR byte1 (addr 3) = 0xFF, OUT byte1 (addr 1) = 0xA5 -> o_pins[15:8] = 0xA5 and o_pins_oe[15:8] = 0xFF, 1 cycle after the second commit; bits [7:0] remain 0.
- Write FSEL addr 7*NB = 0x01 (pin0 = alt1) with i_alt_out[0]=1, i_alt_oe[0]=1 -> o_pins[0]=1, o_pins_oe[0]=1. Write 0x00 -> reverts to OUT/DIR.
- IRQ_EN=0x01, IRQ_RISE=0x01; drive i_pins[0] 0->1 -> STATUS byte0 = 0x01 and o_irq=1 after 3 edges. Falling edge causes no change. W1C 0x01 -> o_irq=0.
- Hold i_phi2 high 4 cycles with i_en=1, i_rw=0 -> exactly one commit, at the phi2 fall, using the last captured data.
- Rising edge on pin 2 coincident with a W1C of bit 2 -> STATUS bit 2 stays 1. Assert i_reset with a write pending -> no commit occurs and all state is 0.
